// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA controller.
package dma_pkg;

   localparam int WORD_BYTES      = 4;
   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR_GAP = 3'd2,
      ST_WR     = 3'd3,
      ST_RD_GAP = 3'd4,
      ST_FIN    = 3'd5
   } state_t;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// Wishbone classic bus bundle between the DMA master and a memory slave.
interface dma_xfer_ctrl_if;

   // Handshake: a request is live while cyc && stb; the master holds adr/we/sel/dat_w
   // stable until the slave answers with a single-cycle ack (done) or err (abort).
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output dat_r, ack, err
   );

endinterface

// File: rtl/dma_timeout_cnt.sv
// Counts cycles spent waiting on a bus response; expire fires on the LIMIT-th cycle.
module dma_timeout_cnt #(
   parameter int LIMIT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || load) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expire = en && !load && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Single-channel word-copy DMA: reads one word, writes it, repeats, with abort on err/timeout.
module dma_xfer_ctrl
   import dma_pkg::*;
#(
   parameter int TIMEOUT   = DEFAULT_TIMEOUT,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_go,
   input  logic                 i_ie,
   input  logic [31:0]          i_src_addr,
   input  logic [31:0]          i_dst_addr,
   input  logic [LEN_WIDTH-1:0] i_len,
   input  logic                 i_done_if,
   output logic                 o_busy,
   output logic                 o_done_if_set,
   output logic                 o_err,
   output logic                 o_irq,
   output state_t               o_dbg_state,
   dma_xfer_ctrl_if.master      wb
);

   state_t               state;
   logic                 go_q;
   logic                 go_armed;
   logic [31:0]          src_ptr;
   logic [31:0]          dst_ptr;
   logic [LEN_WIDTH-1:0] count;
   logic [31:0]          buffer;
   logic                 cyc_q, stb_q, we_q;
   logic [31:0]          adr_q, dat_w_q;
   logic [3:0]           sel_q;
   logic                 busy_q, done_q, err_q;
   logic                 go_rise;
   logic                 tmo_en, tmo_expire;

   // go_armed stays low after reset until go is seen low, so a go held across reset cannot start.
   assign go_rise = i_go && !go_q && go_armed;
   assign tmo_en  = (state == ST_RD) || (state == ST_WR);

   dma_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .load   (!tmo_en),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         go_q     <= 1'b0;
         go_armed <= 1'b0;
         src_ptr  <= '0;
         dst_ptr  <= '0;
         count    <= '0;
         buffer   <= '0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_w_q  <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         go_q     <= i_go;
         go_armed <= go_armed || !i_go;
         done_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go_rise) begin
                  src_ptr <= i_src_addr;
                  dst_ptr <= i_dst_addr;
                  count   <= i_len;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  if (i_len == '0) begin
                     state  <= ST_FIN;
                     done_q <= 1'b1;
                  end else begin
                     state <= ST_RD;
                     cyc_q <= 1'b1;
                     stb_q <= 1'b1;
                     we_q  <= 1'b0;
                     adr_q <= i_src_addr;
                     sel_q <= 4'hF;
                  end
               end
            end
            ST_RD: begin
               // err is tested first so it wins over a coincident ack.
               if (wb.err || tmo_expire) begin
                  cyc_q  <= 1'b0;
                  stb_q  <= 1'b0;
                  sel_q  <= '0;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= ST_FIN;
               end else if (wb.ack) begin
                  buffer <= wb.dat_r;
                  cyc_q  <= 1'b0;
                  stb_q  <= 1'b0;
                  sel_q  <= '0;
                  state  <= ST_WR_GAP;
               end
            end
            ST_WR_GAP: begin
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               we_q    <= 1'b1;
               adr_q   <= dst_ptr;
               dat_w_q <= buffer;
               sel_q   <= 4'hF;
               state   <= ST_WR;
            end
            ST_WR: begin
               if (wb.err || tmo_expire) begin
                  cyc_q  <= 1'b0;
                  stb_q  <= 1'b0;
                  we_q   <= 1'b0;
                  sel_q  <= '0;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= ST_FIN;
               end else if (wb.ack) begin
                  src_ptr <= src_ptr + 32'(WORD_BYTES);
                  dst_ptr <= dst_ptr + 32'(WORD_BYTES);
                  count   <= count - LEN_WIDTH'(1);
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  if (count == LEN_WIDTH'(1)) begin
                     done_q <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     state <= ST_RD_GAP;
                  end
               end
            end
            ST_RD_GAP: begin
               cyc_q <= 1'b1;
               stb_q <= 1'b1;
               we_q  <= 1'b0;
               adr_q <= src_ptr;
               sel_q <= 4'hF;
               state <= ST_RD;
            end
            ST_FIN: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb.cyc        = cyc_q;
   assign wb.stb        = stb_q;
   assign wb.we         = we_q;
   assign wb.adr        = adr_q;
   assign wb.dat_w      = dat_w_q;
   assign wb.sel        = sel_q;
   assign o_busy        = busy_q;
   assign o_done_if_set = done_q;
   assign o_err         = err_q;
   assign o_irq         = i_ie && i_done_if;
   assign o_dbg_state   = state;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl against a one-cycle-ack Wishbone memory model.
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_go = 1'b0;
  logic        i_ie = 1'b0;
  logic        i_done_if = 1'b0;
  logic [31:0] i_src_addr = '0;
  logic [31:0] i_dst_addr = '0;
  logic [15:0] i_len = '0;
  logic        o_busy, o_done_if_set, o_err, o_irq;
  state_t      o_dbg_state;

  dma_xfer_ctrl_if wb ();

  dma_xfer_ctrl #(.TIMEOUT(8), .LEN_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(i_go), .i_ie(i_ie),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
    .i_done_if(i_done_if), .o_busy(o_busy), .o_done_if_set(o_done_if_set),
    .o_err(o_err), .o_irq(o_irq), .o_dbg_state(o_dbg_state), .wb(wb)
  );

  // clock
  always #5 i_clk = ~i_clk;

  // slave memory model: src_mem is read-only stimulus, dst_mem collects writes
  logic [31:0] src_mem [0:1023];
  logic [31:0] dst_mem [0:1023];
  logic [31:0] rd_adr_q[$];
  logic [31:0] exp_q[$];
  int          rd_n = 0;
  int          wr_cnt = 0;
  int          err_on_rd = 0;
  bit          no_ack = 1'b0;

  always @(posedge i_clk) begin
    logic [9:0] idx;
    idx = wb.adr[11:2];
    if (i_rst) begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      wb.dat_r <= '0;
    end else if (wb.cyc && wb.stb && !wb.ack && !wb.err) begin
      if (!no_ack) begin
        if (!wb.we && (rd_n + 1 == err_on_rd)) begin
          wb.err <= 1'b1;
        end else begin
          wb.ack <= 1'b1;
          if (wb.we) begin
            dst_mem[idx] <= wb.dat_w;
            wr_cnt++;
          end else begin
            wb.dat_r <= src_mem[idx];
            rd_adr_q.push_back(wb.adr);
          end
        end
        if (!wb.we) rd_n++;
      end
    end else begin
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
    end
  end

  // per-cycle observation state, owned by the stimulus process
  int n_assert = 0;
  int n_fail = 0;
  int ncyc = 0;
  int first_cyc_at, cyc_fall_at, busy_fall_at, err_at, done_at;
  int done_cnt, cyc_hi, busy_hi;
  bit cyc_prev = 1'b0;
  bit busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    ncyc++;
    if (wb.cyc && !cyc_prev && first_cyc_at < 0) first_cyc_at = ncyc;
    if (!wb.cyc && cyc_prev) cyc_fall_at = ncyc;
    if (!o_busy && busy_prev) busy_fall_at = ncyc;
    cyc_prev = wb.cyc;
    busy_prev = o_busy;
    if (wb.err) err_at = ncyc;
    if (o_done_if_set) begin
      done_cnt++;
      done_at = ncyc;
    end
    cyc_hi += int'(wb.cyc);
    busy_hi += int'(o_busy);
  endtask

  task automatic clr();
    first_cyc_at = -1;
    cyc_fall_at = -1;
    busy_fall_at = -1;
    err_at = -1;
    done_at = -1;
    done_cnt = 0;
    cyc_hi = 0;
    busy_hi = 0;
  endtask

  task automatic go_pulse();
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_within_budget", 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    int wr_base;
    int rd_base;
    int k;
    for (int i = 0; i < 1024; i++) src_mem[i] = 32'hC0DE_0000 | 32'(i);
    clr();

    // reset state
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    chk("rst_stb", 32'(wb.stb), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done_if_set), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_adr", wb.adr, 32'd0);
    chk("rst_sel", 32'(wb.sel), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // two-word copy, with a go re-pulse and CSR scribble mid-transfer
    clr();
    wr_base = wr_cnt;
    i_src_addr = 32'h100;
    i_dst_addr = 32'h200;
    i_len = 16'd2;
    go_pulse();
    tick();
    i_go = 1'b1;
    i_src_addr = 32'hDEAD_0000;
    i_len = 16'd7;
    tick();
    i_go = 1'b0;
    wait_done(100);
    repeat (15) tick();
    exp_q.push_back(32'hC0DE_0040);
    exp_q.push_back(32'hC0DE_0041);
    for (int i = 0; i < 2; i++) chk("copy_word", dst_mem[10'h80 + 10'(i)], exp_q.pop_front());
    chk("copy_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    chk("copy_done_latency", 32'(done_at - first_cyc_at), 32'd11);
    chk("copy_busy_fall", 32'(busy_fall_at - done_at), 32'd1);
    chk("copy_cyc_cycles", 32'(cyc_hi), 32'd8);
    chk("copy_done_count", 32'(done_cnt), 32'd1);
    chk("copy_err", 32'(o_err), 32'd0);
    chk("copy_idle", 32'(o_busy), 32'd0);

    // zero-length transfer
    clr();
    i_len = 16'd0;
    go_pulse();
    wait_done(20);
    repeat (5) tick();
    chk("zero_cyc_cycles", 32'(cyc_hi), 32'd0);
    chk("zero_busy_cycles", 32'(busy_hi), 32'd1);
    chk("zero_done_count", 32'(done_cnt), 32'd1);
    chk("zero_err", 32'(o_err), 32'd0);

    // slave error on the second read of a four-word copy
    clr();
    wr_base = wr_cnt;
    err_on_rd = rd_n + 2;
    i_src_addr = 32'h300;
    i_dst_addr = 32'h400;
    i_len = 16'd4;
    go_pulse();
    wait_done(100);
    repeat (5) tick();
    err_on_rd = 0;
    chk("err_cyc_drop", 32'(cyc_fall_at - err_at), 32'd1);
    chk("err_wr_count", 32'(wr_cnt - wr_base), 32'd1);
    chk("err_word0", dst_mem[10'h100], 32'hC0DE_00C0);
    chk("err_flag", 32'(o_err), 32'd1);
    chk("err_done_count", 32'(done_cnt), 32'd1);

    // silent slave: timeout after 8 cycles, then a good transfer clears o_err
    clr();
    no_ack = 1'b1;
    i_src_addr = 32'h100;
    i_dst_addr = 32'h700;
    i_len = 16'd2;
    go_pulse();
    wait_done(60);
    repeat (3) tick();
    no_ack = 1'b0;
    chk("tmo_cyc_cycles", 32'(cyc_hi), 32'd8);
    chk("tmo_err", 32'(o_err), 32'd1);
    chk("tmo_done_count", 32'(done_cnt), 32'd1);
    clr();
    i_len = 16'd1;
    go_pulse();
    chk("tmo_err_cleared_on_start", 32'(o_err), 32'd0);
    wait_done(40);
    repeat (3) tick();
    chk("tmo_retry_word", dst_mem[10'h1C0], 32'hC0DE_0040);
    chk("tmo_retry_err", 32'(o_err), 32'd0);

    // source pointer wraps past the top of the address space
    clr();
    rd_base = rd_adr_q.size();
    i_src_addr = 32'hFFFF_FFFC;
    i_dst_addr = 32'h500;
    i_len = 16'd2;
    go_pulse();
    wait_done(100);
    repeat (3) tick();
    chk("wrap_rd_count", 32'(rd_adr_q.size() - rd_base), 32'd2);
    if (rd_adr_q.size() >= rd_base + 2) begin
      chk("wrap_rd_adr0", rd_adr_q[rd_base], 32'hFFFF_FFFC);
      chk("wrap_rd_adr1", rd_adr_q[rd_base + 1], 32'h0000_0000);
    end
    chk("wrap_word0", dst_mem[10'h140], 32'hC0DE_03FF);
    chk("wrap_word1", dst_mem[10'h141], 32'hC0DE_0000);

    // go held high through completion must not restart
    clr();
    i_src_addr = 32'h100;
    i_dst_addr = 32'h600;
    i_len = 16'd1;
    i_go = 1'b1;
    tick();
    wait_done(40);
    repeat (10) tick();
    chk("hold_done_count", 32'(done_cnt), 32'd1);
    chk("hold_idle", 32'(o_busy), 32'd0);
    chk("hold_word", dst_mem[10'h180], 32'hC0DE_0040);

    // reset in the middle of a write, go still high
    i_len = 16'd3;
    i_go = 1'b0;
    tick();
    i_go = 1'b1;
    clr();
    k = 0;
    while (o_dbg_state != ST_WR && k < 50) begin
      tick();
      k++;
    end
    chk("mid_reached_wr", 32'(o_dbg_state), 32'(ST_WR));
    i_rst = 1'b1;
    tick();
    chk("mid_rst_cyc", 32'(wb.cyc), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done_if_set), 32'd0);
    i_rst = 1'b0;
    clr();
    repeat (12) tick();
    chk("post_rst_no_cyc", 32'(cyc_hi), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt), 32'd0);
    i_go = 1'b0;
    tick();
    clr();
    go_pulse();
    wait_done(100);
    repeat (3) tick();
    chk("restart_word2", dst_mem[10'h182], 32'hC0DE_0042);
    chk("restart_done_count", 32'(done_cnt), 32'd1);

    // interrupt output
    for (int m = 0; m < 4; m++) begin
      i_ie = m[0];
      i_done_if = m[1];
      tick();
      chk("irq", 32'(o_irq), 32'(m == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
